// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divider sequencer: operand width and FSM state encoding.
package div_ctrl_pkg;
  localparam int DIV_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_e;
endpackage

// File: rtl/div_ctrl_if.sv
// Execute-stage request/result handshake plus the three AXI-stream channels of the divider IP.
interface div_ctrl_if
  import div_ctrl_pkg::*;
#(
  parameter int DW = DIV_W
);
  logic          req_valid;
  logic          req_signed;
  logic [DW-1:0] req_src1;
  logic [DW-1:0] req_src2;
  logic          cancel;
  logic          busy;
  logic          res_valid;
  logic [DW-1:0] res_quo;
  logic [DW-1:0] res_rem;
  logic          res_ack;
  logic          dividend_tvalid;
  logic [DW-1:0] dividend_tdata;
  logic          dividend_tready;
  logic          divisor_tvalid;
  logic [DW-1:0] divisor_tdata;
  logic          divisor_tready;
  logic          dout_tvalid;
  logic [2*DW-1:0] dout_tdata;

  modport slave (
    input  req_valid, req_signed, req_src1, req_src2, cancel, res_ack,
    input  dividend_tready, divisor_tready, dout_tvalid, dout_tdata,
    output busy, res_valid, res_quo, res_rem,
    output dividend_tvalid, dividend_tdata, divisor_tvalid, divisor_tdata
  );

  modport master (
    output req_valid, req_signed, req_src1, req_src2, cancel, res_ack,
    output dividend_tready, divisor_tready, dout_tvalid, dout_tdata,
    input  busy, res_valid, res_quo, res_rem,
    input  dividend_tvalid, dividend_tdata, divisor_tvalid, divisor_tdata
  );
endinterface

// File: rtl/div_ctrl_chk.sv
// Protocol checker: the execute stage must hold req_valid while the sequencer is busy, unless it cancelled.
module div_ctrl_chk (
  input logic clk,
  input logic reset,
  input logic req_valid,
  input logic cancel,
  input logic busy
);
  logic cancel_seen_q;

  // Remember a cancel until the sequencer has gone idle again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cancel_seen_q <= 1'b0;
    end else begin
      cancel_seen_q <= busy ? (cancel_seen_q | cancel) : 1'b0;
    end
  end

  a_req_held: assert property (@(posedge clk) disable iff (reset)
    (busy && !cancel_seen_q && !cancel) |-> req_valid);
endmodule

// File: rtl/div_sign_fix.sv
// Two's-complement conditional negate: magnitude of a signed operand, or sign restore of a result.
module div_sign_fix #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] x,
  input  logic          neg,
  output logic [DW-1:0] y
);
  assign y = neg ? (~x + DW'(1)) : x;
endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer around the unsigned AXI-stream divider IP, with flush draining.
// Optional macro DIV_CTRL_ZERO_BYPASS_EN: divide by zero skips the IP and completes directly.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DW = DIV_W
) (
  input logic       clk,
  input logic       reset,
  div_ctrl_if.slave bus
);
  state_e        state_q, state_d;
  logic [DW-1:0] dividend_q, dividend_d;
  logic [DW-1:0] divisor_q, divisor_d;
  logic          q_neg_q, q_neg_d;
  logic          r_neg_q, r_neg_d;
  logic          dividend_sent_q, dividend_sent_d;
  logic          divisor_sent_q, divisor_sent_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [DW-1:0] rem_q, rem_d;
  logic          busy_q, busy_d;
  logic          res_valid_q, res_valid_d;
  logic          dividend_tvalid_q, dividend_tvalid_d;
  logic          divisor_tvalid_q, divisor_tvalid_d;

  logic [DW-1:0] src1_mag, src2_mag, quo_fix, rem_fix;
  logic          src1_neg, src2_neg;
  logic          dividend_done, divisor_done;

  assign src1_neg = bus.req_signed & bus.req_src1[DW-1];
  assign src2_neg = bus.req_signed & bus.req_src2[DW-1];

  div_sign_fix #(.DW(DW)) u_fix_src1 (.x(bus.req_src1), .neg(src1_neg), .y(src1_mag));
  div_sign_fix #(.DW(DW)) u_fix_src2 (.x(bus.req_src2), .neg(src2_neg), .y(src2_mag));
  div_sign_fix #(.DW(DW)) u_fix_quo (.x(bus.dout_tdata[2*DW-1:DW]), .neg(q_neg_q), .y(quo_fix));
  div_sign_fix #(.DW(DW)) u_fix_rem (.x(bus.dout_tdata[DW-1:0]), .neg(r_neg_q), .y(rem_fix));

  // A channel counts as delivered if it was accepted earlier or is being accepted now.
  assign dividend_done = dividend_sent_q | (dividend_tvalid_q & bus.dividend_tready);
  assign divisor_done  = divisor_sent_q  | (divisor_tvalid_q  & bus.divisor_tready);

  // Next-state, operand capture, result correction and registered-output decode.
  always_comb begin
    state_d         = state_q;
    dividend_d      = dividend_q;
    divisor_d       = divisor_q;
    q_neg_d         = q_neg_q;
    r_neg_d         = r_neg_q;
    dividend_sent_d = dividend_sent_q;
    divisor_sent_d  = divisor_sent_q;
    quo_d           = quo_q;
    rem_d           = rem_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && !bus.cancel) begin
          dividend_d      = src1_mag;
          divisor_d       = src2_mag;
          q_neg_d         = bus.req_signed & (bus.req_src1[DW-1] ^ bus.req_src2[DW-1]);
          r_neg_d         = src1_neg;
          dividend_sent_d = 1'b0;
          divisor_sent_d  = 1'b0;
`ifdef DIV_CTRL_ZERO_BYPASS_EN
          if (bus.req_src2 == '0) begin
            quo_d   = '1;
            rem_d   = bus.req_src1;
            state_d = DONE;
          end else begin
            state_d = SEND;
          end
`else
          state_d = SEND;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        dividend_sent_d = dividend_done;
        divisor_sent_d  = divisor_done;
        // Once the IP holds any operand it will eventually produce a result that must be drained.
        if (bus.cancel) begin
          if (!dividend_done && !divisor_done) begin
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else if (dividend_done && divisor_done) begin
          state_d = WAIT;
        end else begin
          state_d = SEND;
        end
      end
      WAIT: begin
        if (bus.cancel) begin
          state_d = bus.dout_tvalid ? IDLE : DRAIN;
        end else if (bus.dout_tvalid) begin
          quo_d   = quo_fix;
          rem_d   = rem_fix;
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        if (bus.cancel || bus.res_ack) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      DRAIN: begin
        dividend_sent_d = dividend_done;
        divisor_sent_d  = divisor_done;
        if (dividend_sent_q && divisor_sent_q && bus.dout_tvalid) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == IDLE) begin
      dividend_sent_d = 1'b0;
      divisor_sent_d  = 1'b0;
    end else begin
      dividend_sent_d = dividend_sent_d;
    end

    busy_d            = (state_d != IDLE);
    res_valid_d       = (state_d == DONE);
    dividend_tvalid_d = ((state_d == SEND) || (state_d == DRAIN)) && !dividend_sent_d;
    divisor_tvalid_d  = ((state_d == SEND) || (state_d == DRAIN)) && !divisor_sent_d;
  end

  // State, operand, result and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      dividend_q        <= '0;
      divisor_q         <= '0;
      q_neg_q           <= 1'b0;
      r_neg_q           <= 1'b0;
      dividend_sent_q   <= 1'b0;
      divisor_sent_q    <= 1'b0;
      quo_q             <= '0;
      rem_q             <= '0;
      busy_q            <= 1'b0;
      res_valid_q       <= 1'b0;
      dividend_tvalid_q <= 1'b0;
      divisor_tvalid_q  <= 1'b0;
    end else begin
      state_q           <= state_d;
      dividend_q        <= dividend_d;
      divisor_q         <= divisor_d;
      q_neg_q           <= q_neg_d;
      r_neg_q           <= r_neg_d;
      dividend_sent_q   <= dividend_sent_d;
      divisor_sent_q    <= divisor_sent_d;
      quo_q             <= quo_d;
      rem_q             <= rem_d;
      busy_q            <= busy_d;
      res_valid_q       <= res_valid_d;
      dividend_tvalid_q <= dividend_tvalid_d;
      divisor_tvalid_q  <= divisor_tvalid_d;
    end
  end

  assign bus.busy            = busy_q;
  assign bus.res_valid       = res_valid_q;
  assign bus.res_quo         = quo_q;
  assign bus.res_rem         = rem_q;
  assign bus.dividend_tvalid = dividend_tvalid_q;
  assign bus.dividend_tdata  = dividend_q;
  assign bus.divisor_tvalid  = divisor_tvalid_q;
  assign bus.divisor_tdata   = divisor_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural unsigned divider IP on the stream channels.
module tb_div_ctrl;
  localparam int IP_LAT = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  div_ctrl_if #(.DW(32)) bus ();

  div_ctrl #(.DW(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  div_ctrl_chk chk (.clk(clk), .reset(reset), .req_valid(bus.req_valid),
                    .cancel(bus.cancel), .busy(bus.busy));

  // Behavioural divider IP: collects both operands, answers IP_LAT+1 cycles later.
  logic        ip_have_a, ip_have_b;
  logic [31:0] ip_a, ip_b;
  int          ip_cnt;
  int          dout_count;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ip_have_a <= 1'b0; ip_have_b <= 1'b0; ip_a <= 32'd0; ip_b <= 32'd0;
      ip_cnt <= 0; dout_count <= 0;
      bus.dout_tvalid <= 1'b0; bus.dout_tdata <= 64'd0;
    end else begin
      bus.dout_tvalid <= 1'b0;
      if (bus.dividend_tvalid && bus.dividend_tready) begin ip_a <= bus.dividend_tdata; ip_have_a <= 1'b1; end
      if (bus.divisor_tvalid && bus.divisor_tready) begin ip_b <= bus.divisor_tdata; ip_have_b <= 1'b1; end
      if (ip_have_a && ip_have_b) begin
        ip_have_a <= 1'b0; ip_have_b <= 1'b0; ip_cnt <= IP_LAT;
      end else if (ip_cnt > 0) begin
        ip_cnt <= ip_cnt - 1;
        if (ip_cnt == 1) begin
          bus.dout_tvalid <= 1'b1;
          bus.dout_tdata  <= (ip_b == 32'd0) ? {32'hFFFF_FFFF, ip_a} : {ip_a / ip_b, ip_a % ip_b};
          dout_count      <= dout_count + 1;
        end
      end
    end
  end

  task automatic drive_req(input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = 1'b1; bus.req_signed = s; bus.req_src1 = a; bus.req_src2 = b;
  endtask

  task automatic wait_res(output logic [31:0] quo, output logic [31:0] rem, output bit got);
    got = 1'b0; quo = 32'd0; rem = 32'd0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.res_valid) begin got = 1'b1; quo = bus.res_quo; rem = bus.res_rem; end
    end
    if (got) begin
      bus.res_ack = 1'b1;
      @(negedge clk);
      bus.res_ack = 1'b0; bus.req_valid = 1'b0;
    end else begin
      bus.cancel = 1'b1; bus.req_valid = 1'b0;
      @(negedge clk);
      bus.cancel = 1'b0;
    end
  endtask

  task automatic run_req(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] quo, output logic [31:0] rem, output bit got);
    @(negedge clk);
    drive_req(s, a, b);
    wait_res(quo, rem, got);
  endtask

  task automatic test_reset;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
    checks++; if ({bus.dividend_tvalid, bus.divisor_tvalid} !== 2'b00) begin failures++; $display("FAIL reset_tvalid got=%b exp=00", {bus.dividend_tvalid, bus.divisor_tvalid}); end
    checks++; if ({bus.res_quo, bus.res_rem} !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", {bus.res_quo, bus.res_rem}); end
  endtask

  task automatic test_divu;
    bit seen = 1'b0;
    @(negedge clk);
    drive_req(1'b0, 32'd100, 32'd7);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.dout_tvalid) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL divu_dout_timeout got=0 exp=1"); end
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL divu_early_valid got=%b exp=0", bus.res_valid); end
    @(negedge clk);
    checks++; if (bus.res_valid !== 1'b1) begin failures++; $display("FAIL divu_latency got=%b exp=1", bus.res_valid); end
    checks++; if (bus.res_quo !== 32'd14) begin failures++; $display("FAIL divu_quo got=%h exp=%h", bus.res_quo, 32'd14); end
    checks++; if (bus.res_rem !== 32'd2) begin failures++; $display("FAIL divu_rem got=%h exp=%h", bus.res_rem, 32'd2); end
    bus.res_ack = 1'b1;
    @(negedge clk);
    bus.res_ack = 1'b0; bus.req_valid = 1'b0;
    checks++; if ({bus.busy, bus.res_valid} !== 2'b00) begin failures++; $display("FAIL divu_ack_idle got=%b exp=00", {bus.busy, bus.res_valid}); end
  endtask

  task automatic test_signed;
    logic [31:0] q, r; bit got;
    run_req(1'b1, 32'hFFFF_FFF9, 32'd2, q, r, got);
    checks++; if (!got || q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_neg7_2 got=%0d/%h/%h exp=1/fffffffd/ffffffff", got, q, r); end
    run_req(1'b1, 32'd7, 32'hFFFF_FFFE, q, r, got);
    checks++; if (!got || q !== 32'hFFFF_FFFD || r !== 32'd1) begin failures++; $display("FAIL div_7_neg2 got=%0d/%h/%h exp=1/fffffffd/00000001", got, q, r); end
    run_req(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, q, r, got);
    checks++; if (!got || q !== 32'h8000_0000 || r !== 32'd0) begin failures++; $display("FAIL div_overflow got=%0d/%h/%h exp=1/80000000/00000000", got, q, r); end
  endtask

  task automatic test_backpressure;
    logic [31:0] q, r, td; bit got; bit held = 1'b1;
    @(negedge clk);
    bus.dividend_tready = 1'b0;
    drive_req(1'b0, 32'd1000, 32'd10);
    @(negedge clk);
    td = bus.dividend_tdata;
    checks++; if ({bus.dividend_tvalid, bus.divisor_tvalid} !== 2'b11) begin failures++; $display("FAIL bp_both_valid got=%b exp=11", {bus.dividend_tvalid, bus.divisor_tvalid}); end
    @(negedge clk);
    checks++; if (bus.divisor_tvalid !== 1'b0) begin failures++; $display("FAIL bp_divisor_drop got=%b exp=0", bus.divisor_tvalid); end
    for (int i = 0; i < 2; i++) begin
      if (bus.dividend_tvalid !== 1'b1 || bus.dividend_tdata !== td) held = 1'b0;
      @(negedge clk);
    end
    if (bus.dividend_tvalid !== 1'b1 || bus.dividend_tdata !== td) held = 1'b0;
    checks++; if (!held || td !== 32'd1000) begin failures++; $display("FAIL bp_dividend_held got=%0d/%h exp=1/%h", held, td, 32'd1000); end
    bus.dividend_tready = 1'b1;
    @(negedge clk);
    checks++; if (bus.dividend_tvalid !== 1'b0) begin failures++; $display("FAIL bp_dividend_drop got=%b exp=0", bus.dividend_tvalid); end
    wait_res(q, r, got);
    checks++; if (!got || q !== 32'd100 || r !== 32'd0) begin failures++; $display("FAIL bp_result got=%0d/%h/%h exp=1/00000064/00000000", got, q, r); end
  endtask

  task automatic test_cancel_wait;
    logic [31:0] q, r; bit got; bit quiet = 1'b1; int dc;
    @(negedge clk);
    drive_req(1'b0, 32'd50, 32'd5);
    repeat (4) @(negedge clk);
    bus.cancel = 1'b1; bus.req_valid = 1'b0;
    @(negedge clk);
    bus.cancel = 1'b0;
    dc = dout_count;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL cw_drain_busy got=%b exp=1", bus.busy); end
    drive_req(1'b0, 32'd9, 32'd3);
    for (int i = 0; i < 40 && dout_count == dc; i++) begin
      if (bus.res_valid) quiet = 1'b0;
      @(negedge clk);
    end
    checks++; if (!quiet || dout_count == dc) begin failures++; $display("FAIL cw_discard got=%0d/%0d exp=1/%0d", quiet, dout_count, dc + 1); end
    wait_res(q, r, got);
    checks++; if (!got || q !== 32'd3 || r !== 32'd0) begin failures++; $display("FAIL cw_next_result got=%0d/%h/%h exp=1/00000003/00000000", got, q, r); end
  endtask

  task automatic test_cancel_half;
    logic [31:0] q, r; bit got; bit quiet = 1'b1; int dc;
    @(negedge clk);
    bus.dividend_tready = 1'b0;
    dc = dout_count;
    drive_req(1'b0, 32'd20, 32'd4);
    repeat (2) @(negedge clk);
    checks++; if ({bus.dividend_tvalid, bus.divisor_tvalid} !== 2'b10) begin failures++; $display("FAIL ch_divisor_only got=%b exp=10", {bus.dividend_tvalid, bus.divisor_tvalid}); end
    bus.cancel = 1'b1; bus.req_valid = 1'b0;
    @(negedge clk);
    bus.cancel = 1'b0;
    checks++; if (bus.dividend_tvalid !== 1'b1 || bus.dividend_tdata !== 32'd20 || bus.busy !== 1'b1) begin failures++; $display("FAIL ch_still_offered got=%b/%h/%b exp=1/00000014/1", bus.dividend_tvalid, bus.dividend_tdata, bus.busy); end
    bus.dividend_tready = 1'b1;
    for (int i = 0; i < 40 && dout_count == dc; i++) begin
      @(negedge clk);
      if (bus.res_valid) quiet = 1'b0;
    end
    checks++; if (!quiet || bus.dout_tdata !== {32'd5, 32'd0}) begin failures++; $display("FAIL ch_drained got=%0d/%h exp=1/%h", quiet, bus.dout_tdata, {32'd5, 32'd0}); end
    @(negedge clk);
    checks++; if ({bus.busy, bus.res_valid} !== 2'b00) begin failures++; $display("FAIL ch_idle got=%b exp=00", {bus.busy, bus.res_valid}); end
    run_req(1'b0, 32'd9, 32'd3, q, r, got);
    checks++; if (!got || q !== 32'd3 || r !== 32'd0) begin failures++; $display("FAIL ch_next_result got=%0d/%h/%h exp=1/00000003/00000000", got, q, r); end
  endtask

  task automatic test_reset_wait;
    bit quiet = 1'b1;
    @(negedge clk);
    drive_req(1'b0, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b1; bus.req_valid = 1'b0;
    #1;
    checks++; if ({bus.busy, bus.res_valid, bus.dividend_tvalid, bus.divisor_tvalid} !== 4'b0000) begin failures++; $display("FAIL rw_outputs got=%b exp=0000", {bus.busy, bus.res_valid, bus.dividend_tvalid, bus.divisor_tvalid}); end
    checks++; if (bus.res_quo !== 32'd0) begin failures++; $display("FAIL rw_quo_cleared got=%h exp=0", bus.res_quo); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.res_valid || bus.busy) quiet = 1'b0;
    end
    checks++; if (!quiet) begin failures++; $display("FAIL rw_no_stale got=0 exp=1"); end
  endtask

  task automatic test_zero;
    logic [31:0] q, r; bit got;
    @(negedge clk);
    drive_req(1'b0, 32'd5, 32'd0);
    @(negedge clk);
`ifdef DIV_CTRL_ZERO_BYPASS_EN
    checks++; if ({bus.res_valid, bus.dividend_tvalid, bus.divisor_tvalid} !== 3'b100) begin failures++; $display("FAIL zb_bypass got=%b exp=100", {bus.res_valid, bus.dividend_tvalid, bus.divisor_tvalid}); end
    checks++; if (bus.res_quo !== 32'hFFFF_FFFF || bus.res_rem !== 32'd5) begin failures++; $display("FAIL zb_result got=%h/%h exp=ffffffff/00000005", bus.res_quo, bus.res_rem); end
    bus.res_ack = 1'b1;
    @(negedge clk);
    bus.res_ack = 1'b0; bus.req_valid = 1'b0;
    got = 1'b1; q = 32'd0; r = 32'd0;
`else
    checks++; if ({bus.res_valid, bus.dividend_tvalid, bus.divisor_tvalid} !== 3'b011) begin failures++; $display("FAIL zero_via_ip got=%b exp=011", {bus.res_valid, bus.dividend_tvalid, bus.divisor_tvalid}); end
    wait_res(q, r, got);
    checks++; if (!got || q !== 32'hFFFF_FFFF || r !== 32'd5) begin failures++; $display("FAIL zero_result got=%0d/%h/%h exp=1/ffffffff/00000005", got, q, r); end
`endif
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL zero_idle got=%b exp=0", bus.busy); end
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_signed = 1'b0; bus.req_src1 = 32'd0; bus.req_src2 = 32'd0;
    bus.cancel = 1'b0; bus.res_ack = 1'b0;
    bus.dividend_tready = 1'b1; bus.divisor_tready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_divu();
    test_signed();
    test_backpressure();
    test_cancel_wait();
    test_cancel_half();
    test_reset_wait();
    test_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
